// File: rtl/vga_fb_arbiter_if.sv
// Drawing-side write handshake and single-port framebuffer RAM port for vga_fb_arbiter.
// The arbiter takes the slave modport; the environment (drawing logic + RAM) the master.
interface vga_fb_arbiter_if #(
    parameter int AW = 16
);
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport slave (
        input  wr_valid, wr_addr, wr_data, mem_rdata,
        output wr_ready, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output wr_valid, wr_addr, wr_data, mem_rdata,
        input  wr_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Shares one synchronous framebuffer RAM port between VGA pixel fetches (absolute
// priority) and drawing-logic writes; fetched pixels emerge two edges after request.
module vga_fb_arbiter #(
    parameter int IMG_W   = 100,
    parameter int IMG_H   = 100,
    parameter int H_START = 145,
    parameter int V_START = 36,
    parameter int AW      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pix_en,
    input  logic [9:0]           h_count,
    input  logic [9:0]           v_count,
    vga_fb_arbiter_if.slave      fb,
    output logic [7:0]           pix_color,
    output logic                 pix_valid,
    output logic                 frame_done,
    output logic                 err_oob
);
    localparam int            NPIX      = IMG_W * IMG_H;
    localparam logic [AW-1:0] NPIX_A    = AW'(NPIX);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam logic [9:0]    H_LO      = 10'(H_START);
    localparam logic [9:0]    H_HI      = 10'(H_START + IMG_W);
    localparam logic [9:0]    V_LO      = 10'(V_START);
    localparam logic [9:0]    V_HI      = 10'(V_START + IMG_H);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          blank1_q, blank1_d;
    logic          rd2_q, rd2_d;
    logic          blank2_q, blank2_d;
    logic [7:0]    pix_color_q, pix_color_d;
    logic          pix_valid_q, pix_valid_d;
    logic          frame_done_q, frame_done_d;
    logic          err_oob_q, err_oob_d;

    logic in_region;
    logic disp_req;
    logic wr_fire;

    assign in_region = (h_count >= H_LO) && (h_count < H_HI) &&
                       (v_count >= V_LO) && (v_count < V_HI);
    assign disp_req  = pix_en && in_region;
    assign fb.wr_ready = rst_n && fb.wr_valid && !disp_req;
    assign wr_fire   = fb.wr_valid && fb.wr_ready;

    always_comb begin
        state_d      = IDLE;
        rd_addr_d    = rd_addr_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        frame_done_d = 1'b0;
        err_oob_d    = err_oob_q;

        if (disp_req) begin
            state_d      = READ;
            mem_addr_d   = rd_addr_q;
            frame_done_d = (rd_addr_q == LAST_ADDR);
            rd_addr_d    = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + AW'(1);
        end else if (wr_fire) begin
            if (fb.wr_addr < NPIX_A) begin
                state_d     = WRITE;
                mem_addr_d  = fb.wr_addr;
                mem_wdata_d = fb.wr_data;
                mem_we_d    = 1'b1;
            end else begin
                err_oob_d = 1'b1;
            end
        end

        // Frame resync happens off-image, so it never races a fetch increment.
        if (pix_en && (h_count == '0) && (v_count == '0)) begin
            rd_addr_d = '0;
        end

        // Two-stage tag pipeline lines up with the RAM's one-cycle read latency.
        blank1_d    = pix_en && !in_region;
        rd2_d       = (state_q == READ);
        blank2_d    = blank1_q;
        pix_color_d = pix_color_q;
        pix_valid_d = pix_valid_q;
        if (rd2_q) begin
            pix_color_d = fb.mem_rdata;
            pix_valid_d = 1'b1;
        end else if (blank2_q) begin
            pix_color_d = '0;
            pix_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rd_addr_q    <= '0;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= '0;
            blank1_q     <= 1'b0;
            rd2_q        <= 1'b0;
            blank2_q     <= 1'b0;
            pix_color_q  <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            err_oob_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_addr_q    <= rd_addr_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            blank1_q     <= blank1_d;
            rd2_q        <= rd2_d;
            blank2_q     <= blank2_d;
            pix_color_q  <= pix_color_d;
            pix_valid_q  <= pix_valid_d;
            frame_done_q <= frame_done_d;
            err_oob_q    <= err_oob_d;
        end
    end

    assign fb.mem_addr  = mem_addr_q;
    assign fb.mem_we    = mem_we_q;
    assign fb.mem_wdata = mem_wdata_q;
    assign pix_color    = pix_color_q;
    assign pix_valid    = pix_valid_q;
    assign frame_done   = frame_done_q;
    assign err_oob      = err_oob_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomized bench for vga_fb_arbiter: a pixel-index/framebuffer-content model predicts
// every port each cycle; a behavioural sync RAM sits on the memory port.
module tb_vga_fb_arbiter;
    localparam int IMG_W   = 100;
    localparam int IMG_H   = 100;
    localparam int H_START = 145;
    localparam int V_START = 36;
    localparam int AW      = 16;
    localparam int NPIX    = IMG_W * IMG_H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic [9:0] h_count = '0;
    logic [9:0] v_count = '0;
    logic [7:0] pix_color;
    logic       pix_valid, frame_done, err_oob;

    vga_fb_arbiter_if #(.AW(AW)) fb ();

    vga_fb_arbiter #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .H_START(H_START), .V_START(V_START), .AW(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .h_count(h_count), .v_count(v_count),
        .fb(fb), .pix_color(pix_color), .pix_valid(pix_valid),
        .frame_done(frame_done), .err_oob(err_oob)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (fb.mem_we) ram[fb.mem_addr] <= fb.mem_wdata;
        fb.mem_rdata <= ram[fb.mem_addr];
    end

    // Reference: pixel index counter plus a copy of framebuffer contents.
    typedef struct { int due; logic [7:0] c; logic v; } pend_t;
    pend_t         pq[$];
    logic [7:0]    model_ram [NPIX];
    int            exp_idx, cyc;
    logic [AW-1:0] exp_addr, last_wa;
    logic [7:0]    exp_wdata, exp_color, last_old;
    logic          exp_we, exp_fd, exp_pv, exp_err;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
    endtask

    task automatic check_outputs();
        check("mem_we", 32'(fb.mem_we), 32'(exp_we));
        check("mem_addr", 32'(fb.mem_addr), 32'(exp_addr));
        check("mem_wdata", 32'(fb.mem_wdata), 32'(exp_wdata));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        check("pix_color", 32'(pix_color), 32'(exp_color));
        check("pix_valid", 32'(pix_valid), 32'(exp_pv));
        check("err_oob", 32'(err_oob), 32'(exp_err));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        if (exp_we) model_ram[last_wa] = last_old;
        exp_idx = 0; exp_addr = '0; exp_wdata = '0; exp_we = 1'b0; exp_fd = 1'b0;
        exp_color = '0; exp_pv = 1'b0; exp_err = 1'b0;
        pq.delete();
        check_outputs();
        check("wr_ready_rst", 32'(fb.wr_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cycle(input logic pe, input logic [9:0] h, input logic [9:0] v,
                         input logic wv, input logic [AW-1:0] wa, input logic [7:0] wd,
                         output logic acc);
        logic inreg, disp;
        pix_en = pe; h_count = h; v_count = v;
        fb.wr_valid = wv; fb.wr_addr = wa; fb.wr_data = wd;
        #1;
        inreg = (int'(h) >= H_START) && (int'(h) < H_START + IMG_W) &&
                (int'(v) >= V_START) && (int'(v) < V_START + IMG_H);
        disp = pe && inreg;
        acc = wv && !disp;
        check("wr_ready", 32'(fb.wr_ready), 32'(acc));
        exp_we = 1'b0;
        exp_fd = 1'b0;
        if (disp) begin
            exp_addr = AW'(exp_idx);
            exp_fd = (exp_idx == NPIX - 1);
            pq.push_back('{due: cyc + 3, c: model_ram[exp_idx], v: 1'b1});
            exp_idx = (exp_idx + 1) % NPIX;
        end else if (acc) begin
            if (int'(wa) < NPIX) begin
                last_wa = wa; last_old = model_ram[wa];
                model_ram[wa] = wd;
                exp_we = 1'b1; exp_addr = wa; exp_wdata = wd;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (pe && !inreg) pq.push_back('{due: cyc + 3, c: 8'h00, v: 1'b0});
        if (pe && h == 10'd0 && v == 10'd0) exp_idx = 0;
        @(posedge clk);
        #1;
        cyc++;
        while (pq.size() > 0 && pq[0].due == cyc) begin
            exp_color = pq[0].c; exp_pv = pq[0].v;
            pq.delete(0);
        end
        check_outputs();
    endtask

    logic          pw_v = 1'b0;
    logic [AW-1:0] pw_a;
    logic [7:0]    pw_d;

    task automatic maybe_new_write();
        if (!pw_v && $urandom_range(0, 2) == 0) begin
            pw_v = 1'b1;
            pw_a = AW'($urandom_range(0, NPIX - 1));
            pw_d = 8'($urandom);
        end
    endtask

    // One pixel period: a strobe cycle then a free cycle, with a held random write.
    task automatic pix_slot(input logic pe, input int h, input int v);
        logic acc;
        maybe_new_write();
        cycle(pe, 10'(h), 10'(v), pw_v, pw_a, pw_d, acc);
        if (acc) pw_v = 1'b0;
        maybe_new_write();
        cycle(1'b0, 10'(h), 10'(v), pw_v, pw_a, pw_d, acc);
        if (acc) pw_v = 1'b0;
    endtask

    logic acc_tb;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        for (int i = 0; i < NPIX; i++) begin
            ram[i] = 8'($urandom);
            model_ram[i] = ram[i];
        end
        ram[0] = 8'hDD;
        model_ram[0] = 8'hDD;
        fb.wr_valid = 1'b0; fb.wr_addr = '0; fb.wr_data = '0;
        cyc = 0; exp_we = 1'b0;
        #1;
        do_reset();

        // First image pixel fetches RAM[0].
        cycle(1'b1, 10'd145, 10'd36, 1'b0, '0, '0, acc_tb);
        cycle(1'b0, 10'd145, 10'd36, 1'b0, '0, '0, acc_tb);
        cycle(1'b0, 10'd145, 10'd36, 1'b0, '0, '0, acc_tb);
        check("first_pixel", 32'(pix_color), 32'h0000_00DD);

        // Write held across a display cycle.
        cycle(1'b1, 10'd146, 10'd36, 1'b1, 16'h0010, 8'h11, acc_tb);
        cycle(1'b0, 10'd146, 10'd36, 1'b1, 16'h0010, 8'h11, acc_tb);
        cycle(1'b0, 10'd146, 10'd36, 1'b0, 16'h0010, 8'h11, acc_tb);

        // Out-of-range write is accepted, dropped, and flagged stickily.
        cycle(1'b0, 10'd0, 10'd1, 1'b1, 16'(NPIX), 8'h55, acc_tb);
        repeat (3) cycle(1'b0, 10'd0, 10'd1, 1'b0, '0, '0, acc_tb);

        // Full frame with blanking strobes and random writes, then wrap to 0.
        pix_slot(1'b1, 0, 0);
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) pix_slot(1'b1, H_START + x, V_START + y);
            pix_slot(1'b1, H_START + IMG_W, V_START + y);
        end
        for (int x = 0; x < 3; x++) pix_slot(1'b1, H_START + x, V_START);

        // Mid-frame resync after 57 fetches.
        pix_slot(1'b1, 0, 0);
        for (int x = 0; x < 57; x++) pix_slot(1'b1, H_START + x, V_START);
        pix_slot(1'b1, 0, 0);
        pix_slot(1'b1, H_START + 57, V_START);
        pix_slot(1'b0, 0, 0);

        // Reset lands while a RAM write is in flight.
        pw_v = 1'b0;
        cycle(1'b0, 10'd0, 10'd2, 1'b1, 16'd5, 8'hA5, acc_tb);
        do_reset();
        cycle(1'b0, 10'd0, 10'd2, 1'b1, 16'd5, 8'h5A, acc_tb);
        cycle(1'b0, 10'd0, 10'd2, 1'b0, 16'd5, 8'h5A, acc_tb);

        pix_slot(1'b1, 0, 0);
        for (int x = 0; x < 20; x++) pix_slot(1'b1, H_START + x, V_START);
        pix_slot(1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
